// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that lets NUM_CORE cores share one data-memory port pair.
// Each granted request is latched, issued as a single ins pulse, and answered with one rsp_valid pulse.
module mem_port_arbiter #(
    parameter int NUM_CORE         = 2,
    parameter int DOUBLEWORD_WIDTH = 64,
    parameter int ADDR_WIDTH_DM    = 8,
    parameter int DATA_TYPE_WIDTH  = 2,
    parameter int LOCK_EN          = 1
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [NUM_CORE-1:0]                     req_valid,
    input  logic [NUM_CORE-1:0]                     req_wr,
    input  logic [NUM_CORE*ADDR_WIDTH_DM-1:0]       req_addr,
    input  logic [NUM_CORE*DATA_TYPE_WIDTH-1:0]     req_type,
    input  logic [NUM_CORE*DOUBLEWORD_WIDTH-1:0]    req_wdata,
    input  logic [NUM_CORE-1:0]                     req_lock,
    output logic [NUM_CORE-1:0]                     req_ready,
    output logic [NUM_CORE-1:0]                     rsp_valid,
    output logic [DOUBLEWORD_WIDTH-1:0]             rsp_rdata,
    output logic [ADDR_WIDTH_DM-1:0]                addr_wr,
    output logic [ADDR_WIDTH_DM-1:0]                addr_rd,
    output logic [DATA_TYPE_WIDTH-1:0]              data_type_wr,
    output logic [DATA_TYPE_WIDTH-1:0]              data_type_rd,
    output logic [DOUBLEWORD_WIDTH-1:0]             data_bus_wr,
    output logic                                    wr_ins,
    output logic                                    rd_ins,
    input  logic [DOUBLEWORD_WIDTH-1:0]             data_bus_rd,
    input  logic                                    wr_idle,
    input  logic                                    rd_idle,
    output logic [$clog2(NUM_CORE)-1:0]             grant_id
);

    localparam int IDW = $clog2(NUM_CORE);
    localparam logic [NUM_CORE-1:0] ONE_HOT0 = {{(NUM_CORE-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ARB   = 3'd0,
        ISSUE = 3'd1,
        GAP   = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t                         state_r;
    state_t                         next_s;
    logic [IDW-1:0]                 ptr_r;
    logic [IDW-1:0]                 grant_r;
    logic                           wr_lat_r;
    logic [NUM_CORE-1:0]            req_ready_r;
    logic [NUM_CORE-1:0]            rsp_valid_r;
    logic [DOUBLEWORD_WIDTH-1:0]    rsp_rdata_r;
    logic [ADDR_WIDTH_DM-1:0]       addr_wr_r;
    logic [ADDR_WIDTH_DM-1:0]       addr_rd_r;
    logic [DATA_TYPE_WIDTH-1:0]     type_wr_r;
    logic [DATA_TYPE_WIDTH-1:0]     type_rd_r;
    logic [DOUBLEWORD_WIDTH-1:0]    data_wr_r;
    logic                           wr_ins_r;
    logic                           rd_ins_r;
    logic [NUM_CORE-1:0]            lock_s;
    logic [IDW-1:0]                 sel_s;
    logic [IDW-1:0]                 idx_s;
    logic                           idle_s;

    assign lock_s = (LOCK_EN != 0) ? req_lock : {NUM_CORE{1'b0}};
    assign idle_s = wr_lat_r ? wr_idle : rd_idle;

    // Round-robin pick starting after the last grant; a held lock re-selects the last grant.
    always_comb begin
        sel_s = ptr_r;
        idx_s = ptr_r;
        // Walk the search order backwards so the earliest requester in order is written last.
        for (int i = NUM_CORE; i >= 1; i--) begin
            idx_s = IDW'((int'(ptr_r) + i) % NUM_CORE);
            sel_s = req_valid[idx_s] ? idx_s : sel_s;
        end
        sel_s = (lock_s[ptr_r] && req_valid[ptr_r]) ? ptr_r : sel_s;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB;
        end else begin
            state_r <= next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ARB: begin
                if (|req_valid) next_s = ISSUE;
                else            next_s = ARB;
            end
            ISSUE: begin
                if (idle_s) next_s = GAP;
                else        next_s = ISSUE;
            end
            GAP:  next_s = WAIT;
            WAIT: begin
                if (idle_s) next_s = RESP;
                else        next_s = WAIT;
            end
            RESP:    next_s = ARB;
            default: next_s = ARB;
        endcase
    end

    // Request latch, memory-side drive and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r       <= IDW'(NUM_CORE - 1);
            grant_r     <= '0;
            wr_lat_r    <= 1'b0;
            req_ready_r <= '0;
            rsp_valid_r <= '0;
            rsp_rdata_r <= '0;
            addr_wr_r   <= '0;
            addr_rd_r   <= '0;
            type_wr_r   <= '0;
            type_rd_r   <= '0;
            data_wr_r   <= '0;
            wr_ins_r    <= 1'b0;
            rd_ins_r    <= 1'b0;
        end else begin
            req_ready_r <= '0;
            rsp_valid_r <= '0;
            wr_ins_r    <= 1'b0;
            rd_ins_r    <= 1'b0;
            case (state_r)
                ARB: begin
                    if (|req_valid) begin
                        req_ready_r <= ONE_HOT0 << sel_s;
                        grant_r     <= sel_s;
                        ptr_r       <= sel_s;
                        wr_lat_r    <= req_wr[sel_s];
                        // Only the port used by this access is reloaded; the other keeps its last value.
                        if (req_wr[sel_s]) begin
                            addr_wr_r <= req_addr[sel_s*ADDR_WIDTH_DM +: ADDR_WIDTH_DM];
                            type_wr_r <= req_type[sel_s*DATA_TYPE_WIDTH +: DATA_TYPE_WIDTH];
                            data_wr_r <= req_wdata[sel_s*DOUBLEWORD_WIDTH +: DOUBLEWORD_WIDTH];
                        end else begin
                            addr_rd_r <= req_addr[sel_s*ADDR_WIDTH_DM +: ADDR_WIDTH_DM];
                            type_rd_r <= req_type[sel_s*DATA_TYPE_WIDTH +: DATA_TYPE_WIDTH];
                        end
                    end
                end
                ISSUE: begin
                    if (idle_s) begin
                        wr_ins_r <= wr_lat_r;
                        rd_ins_r <= ~wr_lat_r;
                    end
                end
                WAIT: begin
                    if (idle_s && !wr_lat_r) rsp_rdata_r <= data_bus_rd;
                end
                RESP:    rsp_valid_r <= ONE_HOT0 << grant_r;
                default: ;
            endcase
        end
    end

    assign req_ready    = req_ready_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_rdata    = rsp_rdata_r;
    assign addr_wr      = addr_wr_r;
    assign addr_rd      = addr_rd_r;
    assign data_type_wr = type_wr_r;
    assign data_type_rd = type_rd_r;
    assign data_bus_wr  = data_wr_r;
    assign wr_ins       = wr_ins_r;
    assign rd_ins       = rd_ins_r;
    assign grant_id     = grant_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with four cores and a
// behavioural round-robin/lock reference plus a simple memory responder.
module tb_mem_port_arbiter;

    localparam int NC = 4;
    localparam int DW = 64;
    localparam int AW = 8;
    localparam int TW = 2;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NC-1:0]     req_valid = '0;
    logic [NC-1:0]     req_wr = '0;
    logic [NC*AW-1:0]  req_addr = '0;
    logic [NC*TW-1:0]  req_type = '0;
    logic [NC*DW-1:0]  req_wdata = '0;
    logic [NC-1:0]     req_lock = '0;
    logic [NC-1:0]     req_ready;
    logic [NC-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [AW-1:0]     addr_wr;
    logic [AW-1:0]     addr_rd;
    logic [TW-1:0]     data_type_wr;
    logic [TW-1:0]     data_type_rd;
    logic [DW-1:0]     data_bus_wr;
    logic              wr_ins;
    logic              rd_ins;
    logic [DW-1:0]     data_bus_rd = '0;
    logic              wr_idle = 1'b1;
    logic              rd_idle = 1'b1;
    logic [IW-1:0]     grant_id;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int last_g  = NC - 1;
    logic [DW-1:0] exp_rdata = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_CORE(NC), .DOUBLEWORD_WIDTH(DW), .ADDR_WIDTH_DM(AW),
        .DATA_TYPE_WIDTH(TW), .LOCK_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_type(req_type), .req_wdata(req_wdata), .req_lock(req_lock),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .addr_wr(addr_wr), .addr_rd(addr_rd),
        .data_type_wr(data_type_wr), .data_type_rd(data_type_rd),
        .data_bus_wr(data_bus_wr), .wr_ins(wr_ins), .rd_ins(rd_ins),
        .data_bus_rd(data_bus_rd), .wr_idle(wr_idle), .rd_idle(rd_idle),
        .grant_id(grant_id)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; the always-true properties are checked here.
    task automatic tick();
        @(posedge clk);
        #1;
        check("no_dual_ins", 64'(wr_ins & rd_ins), 64'd0);
        check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
        check("rsp_onehot0", 64'($onehot0(rsp_valid)), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 64'(req_ready), 64'd0);
        check({tag, "_rsp"}, 64'(rsp_valid), 64'd0);
        check({tag, "_rdata"}, rsp_rdata, 64'd0);
        check({tag, "_ins"}, 64'({wr_ins, rd_ins}), 64'd0);
        check({tag, "_addr"}, 64'({addr_wr, addr_rd}), 64'd0);
        check({tag, "_type"}, 64'({data_type_wr, data_type_rd}), 64'd0);
        check({tag, "_wdata"}, data_bus_wr, 64'd0);
        check({tag, "_gid"}, 64'(grant_id), 64'd0);
    endtask

    task automatic set_req(input int c, input logic v, input logic wr, input logic [AW-1:0] a,
                           input logic [TW-1:0] t, input logic [DW-1:0] d, input logic lk);
        req_valid[c]          = v;
        req_wr[c]             = wr;
        req_addr[c*AW +: AW]  = a;
        req_type[c*TW +: TW]  = t;
        req_wdata[c*DW +: DW] = d;
        req_lock[c]           = lk;
    endtask

    // Reference arbitration: a locked last winner keeps the grant, otherwise first requester after it.
    function automatic int exp_pick(input logic [NC-1:0] v, input logic [NC-1:0] lk, input int last);
        int j;
        j = last;
        if (v[j[IW-1:0]] && lk[j[IW-1:0]]) return last;
        for (int i = 1; i <= NC; i++) begin
            j = (last + i) % NC;
            if (v[j[IW-1:0]]) return j;
        end
        return 0;
    endfunction

    task automatic wait_grant(input string tag, input int c);
        int n;
        n = 0;
        tick();
        while (req_ready == '0 && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, 64'(req_ready), 64'd1 << c);
        check({tag, "_gid"}, 64'(grant_id), 64'(c));
    endtask

    task automatic wait_ins(input string tag, input logic wr, input logic [AW-1:0] a,
                            input logic [TW-1:0] t, input logic [DW-1:0] d);
        int n;
        n = 0;
        tick();
        while (!(wr_ins || rd_ins) && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_wr_ins"}, 64'(wr_ins), 64'(wr));
        check({tag, "_rd_ins"}, 64'(rd_ins), 64'(!wr));
        if (wr) begin
            check({tag, "_addr_wr"}, 64'(addr_wr), 64'(a));
            check({tag, "_type_wr"}, 64'(data_type_wr), 64'(t));
            check({tag, "_data_wr"}, data_bus_wr, d);
        end else begin
            check({tag, "_addr_rd"}, 64'(addr_rd), 64'(a));
            check({tag, "_type_rd"}, 64'(data_type_rd), 64'(t));
        end
    endtask

    task automatic wait_rsp(input string tag, input int c);
        int n;
        n = 0;
        tick();
        while (rsp_valid == '0 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_rsp"}, 64'(rsp_valid), 64'd1 << c);
        check({tag, "_rdata"}, rsp_rdata, exp_rdata);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [TW-1:0] e_type;
        logic [DW-1:0] e_data;
        int            e_core;
        int            busy;

        // Reset state is visible before any clock edge.
        #1;
        check_all_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;

        // Single read from core 1 with an always-idle memory.
        data_bus_rd = 64'h1122334455667788;
        set_req(1, 1'b1, 1'b0, 8'h20, 2'b10, 64'd0, 1'b0);
        tick();
        check("rd_c0_ready", 64'(req_ready), 64'h2);
        check("rd_c0_gid", 64'(grant_id), 64'd1);
        req_valid[1] = 1'b0;
        set_req(1, 1'b0, 1'b1, 8'hFF, 2'b00, 64'd0, 1'b0);
        tick();
        check("rd_c1_rd_ins", 64'(rd_ins), 64'd1);
        check("rd_c1_addr", 64'(addr_rd), 64'h20);
        check("rd_c1_type", 64'(data_type_rd), 64'd2);
        tick();
        check("rd_c2_rd_ins", 64'(rd_ins), 64'd0);
        tick();
        check("rd_c3_rsp", 64'(rsp_valid), 64'd0);
        tick();
        check("rd_c4_rsp", 64'(rsp_valid), 64'h2);
        check("rd_c4_rdata", rsp_rdata, 64'h1122334455667788);
        exp_rdata = 64'h1122334455667788;
        tick();
        check("rd_c5_rsp", 64'(rsp_valid), 64'd0);
        last_g = 1;

        // Write from core 3 against a memory that stays busy for ten cycles.
        set_req(3, 1'b1, 1'b1, 8'h5A, 2'b01, 64'hDEADBEEF01234567, 1'b0);
        wait_grant("bw", 3);
        req_valid[3] = 1'b0;
        tick();
        check("bw_wr_ins", 64'(wr_ins), 64'd1);
        wr_idle = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bw_busy_rsp", 64'(rsp_valid), 64'd0);
            check("bw_busy_addr", 64'(addr_wr), 64'h5A);
            check("bw_busy_data", data_bus_wr, 64'hDEADBEEF01234567);
            check("bw_busy_type", 64'(data_type_wr), 64'd1);
            check("bw_busy_ins", 64'(wr_ins), 64'd0);
        end
        wr_idle = 1'b1;
        tick();
        check("bw_resp_state", 64'(rsp_valid), 64'd0);
        tick();
        check("bw_rsp", 64'(rsp_valid), 64'h8);
        check("bw_rdata_held", rsp_rdata, exp_rdata);
        check("bw_addr_rd_kept", 64'(addr_rd), 64'h20);
        last_g = 3;

        // Core 2 keeps the grant with a lock for three writes while core 0 waits.
        set_req(2, 1'b1, 1'b1, 8'h40, 2'b11, 64'h0000000000000A00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            d = 64'h0000000000000A00 + 64'(k);
            wait_grant("lock", 2);
            if (k == 0) set_req(0, 1'b1, 1'b0, 8'h10, 2'b00, 64'd0, 1'b0);
            if (k == 2) req_lock[2] = 1'b0;
            req_wdata[2*DW +: DW] = d + 64'd1;
            wait_ins("lock", 1'b1, 8'h40, 2'b11, d);
            wait_rsp("lock", 2);
        end
        data_bus_rd = 64'hA5A5A5A55A5A5A5A;
        wait_grant("lock_after", 0);
        req_valid[0] = 1'b0;
        req_valid[2] = 1'b0;
        wait_ins("lock_after", 1'b0, 8'h10, 2'b00, 64'd0);
        exp_rdata = 64'hA5A5A5A55A5A5A5A;
        wait_rsp("lock_after", 0);

        // Reset asserted while the access sits in WAIT aborts it.
        set_req(1, 1'b1, 1'b0, 8'h33, 2'b00, 64'd0, 1'b0);
        wait_grant("rstw", 1);
        req_valid[1] = 1'b0;
        wait_ins("rstw", 1'b0, 8'h33, 2'b00, 64'd0);
        rd_idle = 1'b0;
        tick();
        tick();
        for (int c = 0; c < NC; c++) set_req(c, 1'b1, 1'b0, 8'(8'h80 + c), 2'b10, 64'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        tick();
        check("rst_hold_rsp", 64'(rsp_valid), 64'd0);
        tick();
        check("rst_hold_rsp2", 64'(rsp_valid), 64'd0);
        rd_idle = 1'b1;
        exp_rdata = '0;
        rst_n = 1'b1;

        // All four cores request continuously: grants rotate 0,1,2,3,0.
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                tick();
                check("cont_first_ready", 64'(req_ready), 64'h1);
            end else begin
                wait_grant("cont", k % NC);
            end
            d = {$urandom, $urandom};
            data_bus_rd = d;
            wait_ins("cont", 1'b0, 8'(8'h80 + (k % NC)), 2'b10, 64'd0);
            exp_rdata = d;
            wait_rsp("cont", k % NC);
        end
        req_valid = '0;
        last_g = 0;

        // Randomized traffic checked against the reference arbitration and memory model.
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NC; c++) begin
                if (!req_valid[c] && ($urandom_range(0, 1) == 1))
                    set_req(c, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom),
                            2'($urandom_range(0, 3)), {$urandom, $urandom},
                            ($urandom_range(0, 3) == 0));
            end
            if (req_valid == '0)
                set_req($urandom_range(0, NC - 1), 1'b1, 1'b0, 8'($urandom), 2'b01, 64'd0, 1'b0);
            e_core = exp_pick(req_valid, req_lock, last_g);
            e_wr   = req_wr[e_core];
            e_addr = req_addr[e_core*AW +: AW];
            e_type = req_type[e_core*TW +: TW];
            e_data = req_wdata[e_core*DW +: DW];
            wait_grant("rnd", e_core);
            req_valid[e_core] = 1'b0;
            req_lock[e_core]  = 1'b0;
            d = {$urandom, $urandom};
            data_bus_rd = d;
            busy = $urandom_range(0, 4);
            wait_ins("rnd", e_wr, e_addr, e_type, e_data);
            if (busy > 0) begin
                if (e_wr) wr_idle = 1'b0;
                else      rd_idle = 1'b0;
                repeat (busy) tick();
                wr_idle = 1'b1;
                rd_idle = 1'b1;
            end
            if (!e_wr) exp_rdata = d;
            wait_rsp("rnd", e_core);
            last_g = e_core;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
